// File: rtl/dbus_uncached_responder.sv
// dbus_uncached_responder: services one uncached core load/store at a time on a req/gnt memory port.
// Posted writes are tracked by an outstanding counter; reads wait for it to drain.
module dbus_uncached_responder #(
    parameter int POSTED_WRITE       = 1,
    parameter int MAX_OUTSTANDING_WR = 4,
    parameter int ADDR_WIDTH         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbus_read,
    input  logic                  dbus_write,
    input  logic [ADDR_WIDTH-1:0] dbus_address,
    input  logic [31:0]           dbus_wrdata,
    input  logic [3:0]            dbus_byteenable,
    output logic                  dbus_stall,
    output logic [31:0]           dbus_rddata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_bvalid
);

    typedef enum logic [2:0] {IDLE, DRAIN, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  wr_cnt;
    logic [31:0] rddata_q;
    logic        wr_inc;
    logic        wr_dec;
    logic        cnt_drained;
    logic        cnt_room;

    assign dbus_stall  = (dbus_read | dbus_write) & (state != DONE);
    assign dbus_rddata = rddata_q;

    // A stray bvalid with nothing outstanding is dropped rather than wrapping the counter.
    assign wr_inc      = (state == REQ) & mem_gnt & mem_we;
    assign wr_dec      = mem_bvalid & (wr_cnt != 4'd0);
    assign cnt_drained = (wr_cnt == 4'd0) | ((wr_cnt == 4'd1) & wr_dec & ~wr_inc);
    assign cnt_room    = wr_cnt < 4'(MAX_OUTSTANDING_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_cnt    <= 4'd0;
            rddata_q  <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else begin
            if (wr_inc && !wr_dec)
                wr_cnt <= wr_cnt + 4'd1;
            else if (wr_dec && !wr_inc)
                wr_cnt <= wr_cnt - 4'd1;
            case (state)
                IDLE: begin
                    if (dbus_read || (dbus_write && cnt_room)) begin
                        mem_we    <= dbus_write;
                        mem_addr  <= dbus_address;
                        mem_wdata <= dbus_wrdata;
                        mem_be    <= dbus_byteenable;
                    end
                    if (dbus_read && wr_cnt != 4'd0) begin
                        state <= DRAIN;
                    end else if (dbus_read || (dbus_write && cnt_room)) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt_drained) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= (mem_we && POSTED_WRITE != 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_we && mem_rvalid) begin
                        rddata_q <= mem_rdata;
                        state    <= DONE;
                    end else if (mem_we && cnt_drained) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dbus_uncached_responder.md
Name: dbus_uncached_responder

Overview:
- Slave end of the uncached data-bus handshake driven by the CPU core's MEM stage.
- Accepts one read or write at a time and holds the core with a combinational stall until the request is serviced.
- Converts each access into a single transfer on a simple request/grant memory port, in order, toward the uncached peripheral fabric.
- Supports posted writes, with an outstanding-write counter that orders later reads behind earlier writes.

Parameters:
- POSTED_WRITE, 1: when 1, a write completes to the core on grant. When 0, it completes on mem_bvalid.
- MAX_OUTSTANDING_WR, 4: maximum number of granted writes awaiting mem_bvalid (range 1..15).
- ADDR_WIDTH, 32: physical address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low; deassertion is synchronous to clk.
- dbus_read  in  1  read request, held stable by the core while dbus_stall=1.
- dbus_write  in  1  write request, held stable while dbus_stall=1. Never asserted together with dbus_read.
- dbus_address  in  ADDR_WIDTH  physical byte address.
- dbus_wrdata  in  32  write data.
- dbus_byteenable  in  4  byte lanes.
- dbus_stall  out  1  combinational; high while the presented request has not completed.
- dbus_rddata  out  32  read data, registered, valid in the completion cycle and held until the next read completes.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  address.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle when mem_req=1.
- mem_rvalid  in  1  read data return, one per granted read, in order.
- mem_rdata  in  32  read data.
- mem_bvalid  in  1  write acknowledge, one per granted write, in order.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, wr_cnt=0, rddata_q=0;
  - outputs mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, dbus_rddata=0.
  - dbus_stall is combinational and equals (dbus_read|dbus_write) while in reset.
- State machine: IDLE, DRAIN, REQ, WAIT, DONE.
- dbus_stall = (dbus_read|dbus_write) & (state != DONE).
- IDLE:
  - On a read with wr_cnt!=0: go to DRAIN.
  - On a read with wr_cnt=0: go to REQ.
  - On a write with wr_cnt<MAX_OUTSTANDING_WR: go to REQ.
  - On a write with the counter full: stay in IDLE.
  - The request fields are captured into mem_* registers on the IDLE->REQ or IDLE->DRAIN edge.
- DRAIN: wait until wr_cnt=0 (including a bvalid in this cycle decrementing it to 0), then go to REQ.
- REQ:
  - mem_req=1, with mem_* stable until mem_gnt.
  - On gnt for a read: go to WAIT.
  - On gnt for a write with POSTED_WRITE=1: go to DONE.
  - On gnt for a write with POSTED_WRITE=0: go to WAIT.
- WAIT:
  - Read: on mem_rvalid, rddata_q<=mem_rdata and go to DONE.
  - Non-posted write: wait for the mem_bvalid matching this write, i.e. wr_cnt returning to 0, then go to DONE.
- DONE: one cycle with dbus_stall=0 so the core advances; mem_req=0. Go to IDLE unconditionally. The request visible in this cycle is the old one, not a new one.
- mem_req deasserts the cycle after gnt.
- wr_cnt:
  - Increments on a write grant and decrements on mem_bvalid.
  - If both happen in the same cycle, wr_cnt is unchanged.
  - mem_bvalid when wr_cnt=0 is a protocol error: ignore it and keep wr_cnt=0.
- Minimum latency:
  - Read: 1 cycle IDLE + 1 cycle REQ with gnt + 1 cycle rvalid + 1 cycle DONE, i.e. the stall is high for 3 cycles.
  - Posted write: stall is high for 2 cycles.
- If rvalid arrives in the same cycle as gnt, it is ignored; rvalid is only accepted in WAIT.
- Request withdrawn mid-transaction (core flush, request drops while in REQ/WAIT/DRAIN): the in-flight transfer still runs to completion on the memory side, then DONE then IDLE; rddata_q is updated, and the stall is low because there is no request.
- Reset mid-transaction clears wr_cnt. Responses still in flight after reset are the fabric's responsibility; the fabric is reset together with this block.

Test Plan:
- Single read: read addr 0x1FD0_0010, gnt on the first REQ cycle, rvalid with 0xDEAD_BEEF one cycle later -> stall high exactly 3 cycles; dbus_rddata=0xDEAD_BEEF in DONE and held afterwards.
- Posted write: POSTED_WRITE=1, write 0x1234_5678, be=4'b0011 -> mem_req shows addr/data/be unchanged until gnt; stall low 2 cycles after the request; wr_cnt=1 until bvalid.
- Read after posted writes: 3 back-to-back writes (bvalid withheld), then a read -> FSM sits in DRAIN with mem_req=0 until the 3rd bvalid; the read issues the next cycle.
- Counter full: MAX_OUTSTANDING_WR=2, 3 writes with no bvalid -> the 3rd write stalls in IDLE; one bvalid releases it; wr_cnt never exceeds 2. A simultaneous gnt+bvalid leaves wr_cnt unchanged.
- Non-posted mode: POSTED_WRITE=0, write with bvalid 5 cycles after gnt -> stall high through WAIT; DONE in the cycle after bvalid.
- Asynchronous reset in WAIT with gnt held low: assert rst=0 between clock edges -> mem_req, wr_cnt and state clear immediately, without a clock edge; after release, a new read completes normally.
